game_sequencer: RTL and testbench
=================================

Name: game_sequencer

Overview:
Top-level game-flow FSM for the bullet-hell core. Sequences the state/level/text registers consumed by the screen, music and game-update blocks. Owns the phase encoding and issues level-load strobes to the HP/position/bullet datapath. Consumes enter/pause buttons, the per-frame tick and the current HP values.

Parameters:
MAX_LEVEL, 5, index of the final level; levels run 1..MAX_LEVEL.
TEXT_PAGES, 4, intro text pages shown before each level (1..15).
TEXT_TIMEOUT, 0, frames before a text page auto-advances; 0 means auto-advance is off.

Ports:
clk  in  1  system clock, single domain
rst_n  in  1  asynchronous active-low reset
enter  in  1  enter button, synchronous level, already debounced
pause  in  1  pause button, synchronous level, already debounced
frame_tick  in  1  one-cycle pulse per video frame
player_hp  in  21  current player HP from the game datapath
enemy_hp  in  21  current enemy HP from the game datapath
state  out  4  0 IDLE, 1 PAUSE, 2 PLAY, 3 CLEAR, 4 WIN, 5 LOSE, 6 TEXT
level  out  6  current level; 0 before a game starts
text_id  out  10  text index = level*TEXT_PAGES + page
load_level  out  1  one-cycle strobe: datapath reinitialises HP, positions and bullets for `level`
run  out  1  high only in PLAY; gates the game update
play_frames  out  16  frames elapsed in the current level attempt

Behaviour:
- Reset (async assert, sync release) drives these values:
  - state=IDLE, level=0, text_id=0, page=0.
  - load_level=0, run=0, play_frames=0, arm=0.
  - Edge-detector history = 1, so a button held through reset does not fire until it is released and pressed again.
- Edges: enter_e/pause_e = input & ~prev, with prev registered every cycle. Every transition below is registered, so outputs update one cycle after the triggering edge or tick.
- IDLE: on enter_e, set level=1, page=0 and go to TEXT. pause is ignored.
- TEXT:
  - enter_e with page<TEXT_PAGES-1: page++.
  - enter_e with page=TEXT_PAGES-1: go to PLAY and assert load_level for the one cycle where state first reads PLAY. Also play_frames=0, arm=0.
  - Auto-advance: if TEXT_TIMEOUT≠0, a per-page frame counter advances exactly as enter_e would once TEXT_TIMEOUT frame_ticks have elapsed on the page.
  - The page counter clears on every page change.
  - If enter_e and the timeout coincide, advance only one page.
- PLAY:
  - Each frame_tick: play_frames++, saturating at 0xFFFF.
  - HP checks are evaluated only on frame_tick with arm=1. The first frame_tick after entry sets arm=1 instead of checking, which gives the datapath time to reload HP.
  - Priority, highest first:
    1. pause_e → PAUSE.
    2. player_hp==0 → LOSE (takes precedence even if enemy_hp==0).
    3. enemy_hp==0 → CLEAR.
- PAUSE: pause_e → PLAY with no reload; play_frames and arm are held. enter is ignored.
- CLEAR: enter_e → if level==MAX_LEVEL go to WIN (level held), else level++, page=0, go to TEXT.
- WIN: enter_e → IDLE with level=0, page=0.
- LOSE: enter_e → IDLE with level=0 (see Optional Feature).
- text_id is combinational from the registered level and page. It is forced to 0 in IDLE.
- Arithmetic: level*TEXT_PAGES must fit in 10 bits. Elaboration error if MAX_LEVEL*TEXT_PAGES+TEXT_PAGES-1 > 1023.
- Simultaneous enter_e and pause_e: in PLAY, pause wins. In every other state, only the relevant button acts.
- States 7–15 are illegal and recover to IDLE on the next cycle.

Optional Feature:
- Macro: GAME_SEQ_RETRY_EN.
- Defined: in LOSE, enter_e retries the same level. Go to PLAY, pulse load_level, clear play_frames and arm. pause_e in LOSE returns to IDLE with level=0.
- Undefined: LOSE behaves as above (enter_e → IDLE, pause ignored).

Decomposition:
- Shared package game_pkg holds:
  - The state encoding constants (ST_IDLE=0 … ST_TEXT=6) and STATE_W=4.
  - LEVEL_W=6, TEXT_W=10, HP_W=21.
  - The same package is used by the screen, music and game blocks.
- One sub-module, btn_edge: a rising-edge detector with reset value 1, instantiated for enter and pause.

Test Plan:
1. Reset with enter held high, then release and press → state goes IDLE→TEXT one cycle after the press, level=1, text_id=4.
2. From TEXT, 4 enter presses → text_id steps 4,5,6,7. The 4th press gives state=2 with load_level high for exactly 1 cycle.
3. In PLAY, enemy_hp=0 from the start → no transition on the first frame_tick; state=3 after the second.
4. player_hp=0 and enemy_hp=0 on the same armed tick → state=5. The same tick with pause_e also high → state=1.
5. Play through to level 5, CLEAR, enter → state=4, level=5. Enter again → state=0, level=0, text_id=0.
6. PAUSE with 10 frame_ticks, then resume → play_frames unchanged across the pause. TEXT_TIMEOUT=3 → page advances after 3 ticks with no enter press.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game-flow definitions: phase encoding and datapath widths used by the
// sequencer, screen, music and game-update blocks.
package game_pkg;

    localparam int STATE_W = 4;
    localparam int LEVEL_W = 6;
    localparam int TEXT_W  = 10;
    localparam int HP_W    = 21;
    localparam int FRAME_W = 16;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 4'd0,
        ST_PAUSE = 4'd1,
        ST_PLAY  = 4'd2,
        ST_CLEAR = 4'd3,
        ST_WIN   = 4'd4,
        ST_LOSE  = 4'd5,
        ST_TEXT  = 4'd6
    } game_state_e;

    // Frame counters stick at all-ones rather than wrapping.
    function automatic logic [FRAME_W-1:0] satInc(input logic [FRAME_W-1:0] v);
        return (&v) ? v : v + FRAME_W'(1);
    endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Button/HP inputs and phase outputs of the game sequencer, bundled for the
// surrounding screen, music and game-update blocks.
interface game_sequencer_if;
    import game_pkg::*;

    logic                enter;
    logic                pause;
    logic                frame_tick;
    logic [HP_W-1:0]     player_hp;
    logic [HP_W-1:0]     enemy_hp;
    logic [STATE_W-1:0]  state;
    logic [LEVEL_W-1:0]  level;
    logic [TEXT_W-1:0]   text_id;
    logic                load_level;
    logic                run;
    logic [FRAME_W-1:0]  play_frames;

    modport master (
        output enter, pause, frame_tick, player_hp, enemy_hp,
        input  state, level, text_id, load_level, run, play_frames
    );

    modport slave (
        input  enter, pause, frame_tick, player_hp, enemy_hp,
        output state, level, text_id, load_level, run, play_frames
    );

endinterface

// File: rtl/game_sequencer_btn_edge.sv
// Rising-edge detector for an already debounced button; history resets high so
// a button held through reset must be released before it can fire.
module btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic rise
);

    logic prevReg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prevReg <= 1'b1;
        end else begin
            prevReg <= btn;
        end
    end

    assign rise = btn & ~prevReg;

endmodule

// File: rtl/game_sequencer.sv
// Game-flow FSM: IDLE -> TEXT pages -> PLAY -> CLEAR/LOSE -> ... -> WIN.
// Define GAME_SEQ_RETRY_EN to let enter in LOSE retry the current level.
module game_sequencer
    import game_pkg::*;
#(
    parameter int MAX_LEVEL    = 5,
    parameter int TEXT_PAGES   = 4,
    parameter int TEXT_TIMEOUT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    game_sequencer_if.slave  bus
);

    if ((MAX_LEVEL * TEXT_PAGES + TEXT_PAGES - 1) > 1023) begin : gTextIdRange
        $error("game_sequencer: MAX_LEVEL*TEXT_PAGES+TEXT_PAGES-1 exceeds 1023");
    end
    if (TEXT_PAGES < 1 || TEXT_PAGES > 15) begin : gPagesRange
        $error("game_sequencer: TEXT_PAGES must be 1..15");
    end

    localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(MAX_LEVEL);
    localparam logic [3:0]         LAST_PAGE  = 4'(TEXT_PAGES - 1);
    localparam logic [FRAME_W-1:0] TIMER_LAST = FRAME_W'((TEXT_TIMEOUT == 0) ? 0 : TEXT_TIMEOUT - 1);

    logic enterEdge;
    logic pauseEdge;

    btn_edge uEnterEdge (.clk(clk), .rst_n(rst_n), .btn(bus.enter), .rise(enterEdge));
    btn_edge uPauseEdge (.clk(clk), .rst_n(rst_n), .btn(bus.pause), .rise(pauseEdge));

    logic [STATE_W-1:0] stateReg;
    logic [LEVEL_W-1:0] levelReg;
    logic [3:0]         pageReg;
    logic [FRAME_W-1:0] textTimer;
    logic [FRAME_W-1:0] playFrames;
    logic               armReg;
    logic               runReg;
    logic               loadLevel;

    logic timeoutHit;
    logic textAdvance;
    logic [TEXT_W-1:0] textIdx;

    assign timeoutHit  = (TEXT_TIMEOUT != 0) && bus.frame_tick && (textTimer == TIMER_LAST);
    // A coinciding press and timeout still advance just one page.
    assign textAdvance = enterEdge | timeoutHit;
    assign textIdx     = TEXT_W'(levelReg) * TEXT_W'(TEXT_PAGES) + TEXT_W'(pageReg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg   <= ST_IDLE;
            levelReg   <= '0;
            pageReg    <= '0;
            textTimer  <= '0;
            playFrames <= '0;
            armReg     <= 1'b0;
            runReg     <= 1'b0;
            loadLevel  <= 1'b0;
        end else begin
            loadLevel <= 1'b0;
            case (stateReg)
                ST_IDLE: begin
                    if (enterEdge) begin
                        levelReg  <= LEVEL_W'(1);
                        pageReg   <= '0;
                        textTimer <= '0;
                        stateReg  <= ST_TEXT;
                    end
                end
                ST_TEXT: begin
                    if (textAdvance) begin
                        textTimer <= '0;
                        if (pageReg == LAST_PAGE) begin
                            stateReg   <= ST_PLAY;
                            loadLevel  <= 1'b1;
                            runReg     <= 1'b1;
                            playFrames <= '0;
                            armReg     <= 1'b0;
                        end else begin
                            pageReg <= pageReg + 4'd1;
                        end
                    end else if (bus.frame_tick && (TEXT_TIMEOUT != 0)) begin
                        textTimer <= textTimer + FRAME_W'(1);
                    end
                end
                ST_PLAY: begin
                    if (bus.frame_tick) begin
                        playFrames <= satInc(playFrames);
                    end
                    // First tick after entry only arms, giving the datapath a frame to reload HP.
                    if (pauseEdge) begin
                        stateReg <= ST_PAUSE;
                        runReg   <= 1'b0;
                    end else if (bus.frame_tick) begin
                        if (!armReg) begin
                            armReg <= 1'b1;
                        end else if (bus.player_hp == '0) begin
                            stateReg <= ST_LOSE;
                            runReg   <= 1'b0;
                        end else if (bus.enemy_hp == '0) begin
                            stateReg <= ST_CLEAR;
                            runReg   <= 1'b0;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (pauseEdge) begin
                        stateReg <= ST_PLAY;
                        runReg   <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (enterEdge) begin
                        if (levelReg == LAST_LEVEL) begin
                            stateReg <= ST_WIN;
                        end else begin
                            levelReg  <= levelReg + LEVEL_W'(1);
                            pageReg   <= '0;
                            textTimer <= '0;
                            stateReg  <= ST_TEXT;
                        end
                    end
                end
                ST_WIN: begin
                    if (enterEdge) begin
                        levelReg <= '0;
                        pageReg  <= '0;
                        stateReg <= ST_IDLE;
                    end
                end
                ST_LOSE: begin
`ifdef GAME_SEQ_RETRY_EN
                    if (enterEdge) begin
                        stateReg   <= ST_PLAY;
                        loadLevel  <= 1'b1;
                        runReg     <= 1'b1;
                        playFrames <= '0;
                        armReg     <= 1'b0;
                    end else if (pauseEdge) begin
                        levelReg <= '0;
                        pageReg  <= '0;
                        stateReg <= ST_IDLE;
                    end
`else
                    if (enterEdge) begin
                        levelReg <= '0;
                        pageReg  <= '0;
                        stateReg <= ST_IDLE;
                    end
`endif
                end
                default: begin
                    stateReg <= ST_IDLE;
                    levelReg <= '0;
                    pageReg  <= '0;
                    runReg   <= 1'b0;
                    armReg   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.state       = stateReg;
    assign bus.level       = levelReg;
    assign bus.text_id     = (stateReg == ST_IDLE) ? '0 : textIdx;
    assign bus.load_level  = loadLevel;
    assign bus.run         = runReg;
    assign bus.play_frames = playFrames;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench: dutA uses default parameters, dutB uses TEXT_TIMEOUT=3 for auto-advance.
module tb_game_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;

    game_sequencer_if busA ();
    game_sequencer_if busB ();

    game_sequencer #(.MAX_LEVEL(5), .TEXT_PAGES(4), .TEXT_TIMEOUT(0)) dutA (
        .clk(clk), .rst_n(rst_n), .bus(busA)
    );
    game_sequencer #(.MAX_LEVEL(5), .TEXT_PAGES(4), .TEXT_TIMEOUT(3)) dutB (
        .clk(clk), .rst_n(rst_n), .bus(busB)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("check %-14s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic pressA();
        @(negedge clk); busA.enter = 1'b1;
        @(negedge clk); busA.enter = 1'b0;
    endtask

    task automatic pauseA();
        @(negedge clk); busA.pause = 1'b1;
        @(negedge clk); busA.pause = 1'b0;
    endtask

    task automatic tickA();
        @(negedge clk); busA.frame_tick = 1'b1;
        @(negedge clk); busA.frame_tick = 1'b0;
    endtask

    task automatic tickB();
        @(negedge clk); busB.frame_tick = 1'b1;
        @(negedge clk); busB.frame_tick = 1'b0;
    endtask

    initial begin
        busA.enter = 1'b1; busA.pause = 1'b0; busA.frame_tick = 1'b0;
        busA.player_hp = 21'd1000; busA.enemy_hp = 21'd1000;
        busB.enter = 1'b0; busB.pause = 1'b0; busB.frame_tick = 1'b0;
        busB.player_hp = 21'd1000; busB.enemy_hp = 21'd1000;

        // Reset with enter held
        repeat (3) @(negedge clk);
        check("rst_state", int'(busA.state), 0);
        check("rst_level", int'(busA.level), 0);
        check("rst_text", int'(busA.text_id), 0);
        check("rst_load", int'(busA.load_level), 0);
        check("rst_run", int'(busA.run), 0);
        check("rst_frames", int'(busA.play_frames), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("held_enter", int'(busA.state), 0);
        busA.enter = 1'b0;
        @(negedge clk);

        // Start game, step text pages
        pressA();
        check("start_state", int'(busA.state), 6);
        check("start_level", int'(busA.level), 1);
        check("start_text", int'(busA.text_id), 4);
        for (int p = 5; p <= 7; p++) begin
            pressA();
            check("page_text", int'(busA.text_id), p);
        end
        busA.enemy_hp = 21'd0;
        pressA();
        check("play_state", int'(busA.state), 2);
        check("play_load", int'(busA.load_level), 1);
        check("play_run", int'(busA.run), 1);
        @(negedge clk);
        check("load_pulse", int'(busA.load_level), 0);

        // Arming tick suppresses the HP check
        tickA();
        check("arm_state", int'(busA.state), 2);
        check("arm_frames", int'(busA.play_frames), 1);
        tickA();
        check("clear_state", int'(busA.state), 3);
        check("clear_run", int'(busA.run), 0);
        busA.enemy_hp = 21'd1000;
        pressA();
        check("lvl2_state", int'(busA.state), 6);
        check("lvl2_text", int'(busA.text_id), 8);

        // Level 2: pause holds play_frames
        repeat (4) pressA();
        check("lvl2_play", int'(busA.state), 2);
        tickA();
        tickA();
        check("pre_pause_fr", int'(busA.play_frames), 2);
        pauseA();
        check("pause_state", int'(busA.state), 1);
        check("pause_run", int'(busA.run), 0);
        repeat (10) tickA();
        pressA();
        check("pause_hold", int'(busA.state), 1);
        check("pause_frames", int'(busA.play_frames), 2);
        pauseA();
        check("resume_state", int'(busA.state), 2);
        check("resume_load", int'(busA.load_level), 0);
        check("resume_frames", int'(busA.play_frames), 2);

        // Both HP zero with pause on the same armed tick: pause wins
        busA.player_hp = 21'd0; busA.enemy_hp = 21'd0;
        @(negedge clk); busA.frame_tick = 1'b1; busA.pause = 1'b1;
        @(negedge clk); busA.frame_tick = 1'b0; busA.pause = 1'b0;
        check("pause_prio", int'(busA.state), 1);
        pauseA();
        tickA();
        check("lose_prio", int'(busA.state), 5);
        check("lose_level", int'(busA.level), 2);
        pressA();
        check("lose_idle", int'(busA.state), 0);
        check("lose_lvl0", int'(busA.level), 0);

        // Full playthrough to WIN
        busA.player_hp = 21'd100;
        pressA();
        for (int lvl = 1; lvl <= 5; lvl++) begin
            repeat (4) pressA();
            check("pt_play", int'(busA.state), 2);
            tickA();
            tickA();
            check("pt_clear", int'(busA.state), 3);
            check("pt_level", int'(busA.level), lvl);
            pressA();
            if (lvl < 5) begin
                check("pt_text", int'(busA.text_id), (lvl + 1) * 4);
            end
        end
        check("win_state", int'(busA.state), 4);
        check("win_level", int'(busA.level), 5);
        pressA();
        check("win_idle", int'(busA.state), 0);
        check("win_lvl0", int'(busA.level), 0);
        check("win_text0", int'(busA.text_id), 0);

        // dutB: auto-advance after three frame ticks
        @(negedge clk); busB.enter = 1'b1;
        @(negedge clk); busB.enter = 1'b0;
        check("to_start", int'(busB.text_id), 4);
        tickB();
        tickB();
        check("to_wait", int'(busB.text_id), 4);
        tickB();
        check("to_adv", int'(busB.text_id), 5);
        tickB();
        tickB();
        @(negedge clk); busB.frame_tick = 1'b1; busB.enter = 1'b1;
        @(negedge clk); busB.frame_tick = 1'b0; busB.enter = 1'b0;
        check("to_coincide", int'(busB.text_id), 6);
        repeat (3) tickB();
        check("to_adv2", int'(busB.text_id), 7);
        repeat (3) tickB();
        check("to_play", int'(busB.state), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
